// File: rtl/dmem_wait_responder.sv
// Data-memory responder behind the CPU MEM stage, with programmable wait states.
// Latency: ack is high in the cycle after edge k+WAIT_CYCLES+1 for a request accepted at edge k.
// Backpressure: busy stalls the CPU while a request waits or is in flight; req is ignored during the DONE turn-around cycle.
module dmem_wait_responder #(
   parameter int DEPTH_LOG2  = 5,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  req,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  ack,
   output logic                  busy
);

   localparam int         DEPTH     = 2 ** DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  ack_q, ack_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  mem_wr_en;
   logic [31:0]           mem_q [DEPTH];

   // Next-state, request latching and access decode; inputs are only looked at in IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      rdata_d   = rdata_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      mem_wr_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr;
               we_d    = we;
               wdata_d = wdata;
               cnt_d   = WAIT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               ack_d = 1'b1;
               if (we_q) begin
                  mem_wr_en = 1'b1;
               end else begin
                  rdata_d = mem_q[addr_q];
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Turn-around: a req still held from the finished access is not re-accepted here.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and latched-request registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         rdata_q <= 32'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   // Storage array; reset clears every word so an aborted store leaves no trace.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (mem_wr_en) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   // Stall while waiting, or as soon as a new request shows up in IDLE; never during reset.
   assign busy  = Resetn & ((state_q == S_WAIT) | ((state_q == S_IDLE) & req));

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: one instance with 2 wait states, one with none.
// Table rows drive single transactions; hand sequences cover turn-around and reset abort.
// Expected load data and ack latency come from the table and a scoreboard queue.
module tb_dmem_wait_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        r0_resetn, r0_req, r0_we, r0_ack, r0_busy;
   logic [4:0]  r0_addr;
   logic [31:0] r0_wdata, r0_rdata;
   logic        r1_resetn, r1_req, r1_we, r1_ack, r1_busy;
   logic [4:0]  r1_addr;
   logic [31:0] r1_wdata, r1_rdata;

   dmem_wait_responder #(.DEPTH_LOG2(5), .WAIT_CYCLES(2)) u_dut0 (
      .Clock(clk), .Resetn(r0_resetn), .req(r0_req), .we(r0_we), .addr(r0_addr),
      .wdata(r0_wdata), .rdata(r0_rdata), .ack(r0_ack), .busy(r0_busy));

   dmem_wait_responder #(.DEPTH_LOG2(5), .WAIT_CYCLES(0)) u_dut1 (
      .Clock(clk), .Resetn(r1_resetn), .req(r1_req), .we(r1_we), .addr(r1_addr),
      .wdata(r1_wdata), .rdata(r1_rdata), .ack(r1_ack), .busy(r1_busy));

   typedef struct {
      int          sel;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      bit          scr;
      logic [31:0] exp_rd;
      int          exp_n;
   } row_t;

   typedef struct {
      int          sel;
      logic [31:0] rd;
   } sb_t;

   sb_t         sb_q[$];
   row_t        rows[9];
   logic [31:0] last_rd[2];
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic get_ack(input int sel);
      return (sel == 0) ? r0_ack : r1_ack;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? r0_busy : r1_busy;
   endfunction

   function automatic logic [31:0] get_rdata(input int sel);
      return (sel == 0) ? r0_rdata : r1_rdata;
   endfunction

   task automatic set_in(input int sel, input logic rq, input logic w, input logic [4:0] a,
                         input logic [31:0] d);
      if (sel == 0) begin
         r0_req = rq; r0_we = w; r0_addr = a; r0_wdata = d;
      end else begin
         r1_req = rq; r1_we = w; r1_addr = a; r1_wdata = d;
      end
   endtask

   // Queue the expected rdata for a transaction being presented now.
   task automatic push_exp(input int sel, input logic w, input logic [31:0] load_exp);
      sb_t e;
      e.sel = sel;
      e.rd  = w ? last_rd[sel] : load_exp;
      last_rd[sel] = e.rd;
      sb_q.push_back(e);
   endtask

   // Waits (bounded) for ack; busy must stay high until then. Returns at the ack-cycle negedge.
   task automatic wait_ack(input int sel, input int exp_n, input bit scr, input string nm);
      int  n;
      bit  got;
      sb_t e;
      n   = 0;
      got = 1'b0;
      while (!got && n < 30) begin
         @(negedge clk);
         n++;
         if (get_ack(sel)) got = 1'b1;
         else chk({nm, "_busy_wait"}, 32'(get_busy(sel)), 32'd1);
         if (scr && n == 1) set_in(sel, 1'b0, 1'b0, 5'd6, 32'hFFFFFFFF);
      end
      chk({nm, "_ack_edges"}, got ? n : -1, exp_n);
      if (got) begin
         chk({nm, "_busy_in_ack"}, 32'(get_busy(sel)), 32'd0);
         if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk({nm, "_rdata"}, get_rdata(e.sel), e.rd);
         end
      end
   endtask

   // One transaction from IDLE; on return the DUT is back in IDLE at a negedge.
   task automatic run_row(input row_t r, input string nm);
      set_in(r.sel, 1'b1, r.we, r.addr, r.wdata);
      push_exp(r.sel, r.we, r.exp_rd);
      #1;
      chk({nm, "_busy_req"}, 32'(get_busy(r.sel)), 32'd1);
      wait_ack(r.sel, r.exp_n, r.scr, nm);
      set_in(r.sel, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk({nm, "_ack_drop"}, 32'(get_ack(r.sel)), 32'd0);
      chk({nm, "_busy_idle"}, 32'(get_busy(r.sel)), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acks;
      // sel, we, addr, wdata, scramble, expected load data, ack edge (acceptance edge = 1)
      rows[0] = '{0, 1'b1, 5'd3, 32'h12345678, 1'b0, 32'h0,        4};
      rows[1] = '{0, 1'b0, 5'd3, 32'h0,        1'b0, 32'h12345678, 4};
      rows[2] = '{0, 1'b0, 5'd7, 32'h0,        1'b0, 32'h00000000, 4};
      rows[3] = '{0, 1'b1, 5'd5, 32'hAAAA5555, 1'b1, 32'h0,        4};
      rows[4] = '{0, 1'b0, 5'd5, 32'h0,        1'b0, 32'hAAAA5555, 4};
      rows[5] = '{0, 1'b0, 5'd6, 32'h0,        1'b0, 32'h00000000, 4};
      rows[6] = '{1, 1'b1, 5'd1, 32'h00000011, 1'b0, 32'h0,        2};
      rows[7] = '{1, 1'b0, 5'd1, 32'h0,        1'b0, 32'h00000011, 2};
      rows[8] = '{0, 1'b0, 5'd9, 32'h0,        1'b0, 32'h00000000, 4};
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;

      // Reset with req high: busy must stay low while Resetn is low.
      r0_resetn = 1'b0;
      r1_resetn = 1'b0;
      set_in(0, 1'b1, 1'b1, 5'd2, 32'h5);
      set_in(1, 1'b1, 1'b1, 5'd2, 32'h5);
      repeat (3) @(negedge clk);
      chk("rst_ack0", 32'(r0_ack), 32'd0);
      chk("rst_rdata0", r0_rdata, 32'd0);
      chk("rst_busy0", 32'(r0_busy), 32'd0);
      chk("rst_ack1", 32'(r1_ack), 32'd0);
      chk("rst_busy1", 32'(r1_busy), 32'd0);
      set_in(0, 1'b0, 1'b0, 5'd0, 32'd0);
      set_in(1, 1'b0, 1'b0, 5'd0, 32'd0);
      r0_resetn = 1'b1;
      r1_resetn = 1'b1;
      @(negedge clk);
      chk("idle_busy0", 32'(r0_busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_row(rows[i], $sformatf("row%0d", i));
      end

      // req held through DONE, switched to a load there: the load must not be taken
      // until the edge after DONE, and exactly one ack per transaction.
      set_in(0, 1'b1, 1'b1, 5'd3, 32'h12345678);
      push_exp(0, 1'b1, 32'h0);
      wait_ack(0, 4, 1'b0, "hold_st");
      set_in(0, 1'b1, 1'b0, 5'd3, 32'h0);
      push_exp(0, 1'b0, 32'h12345678);
      wait_ack(0, 5, 1'b0, "hold_ld");
      set_in(0, 1'b0, 1'b0, 5'd0, 32'd0);
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (r0_ack) acks++;
      end
      chk("hold_no_extra_ack", acks, 0);

      // Reset during WAIT of a store aborts it.
      set_in(0, 1'b1, 1'b1, 5'd9, 32'hDEADBEEF);
      @(negedge clk);
      r0_resetn = 1'b0;
      #1;
      chk("abort_busy_rst", 32'(r0_busy), 32'd0);
      acks = 0;
      repeat (2) begin
         @(negedge clk);
         if (r0_ack) acks++;
      end
      r0_resetn = 1'b1;
      set_in(0, 1'b0, 1'b0, 5'd0, 32'd0);
      last_rd[0] = 32'd0;
      repeat (6) begin
         @(negedge clk);
         if (r0_ack) acks++;
      end
      chk("abort_no_ack", acks, 0);
      chk("abort_rdata", r0_rdata, 32'd0);
      run_row(rows[8], "abort_load9");
      chk("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
